// File: rtl/branch_update_ctrl_pkg.sv
// Shared defaults and helpers for the branch predictor update path.
package branch_update_ctrl_pkg;

   localparam int unsigned BP_ENTRY_NUM   = 256;
   localparam int unsigned BP_TRACK_DEPTH = 4;
   localparam int unsigned PERF_CNT_W     = 16;

   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
      return (v == {PERF_CNT_W{1'b1}}) ? v : v + PERF_CNT_W'(1);
   endfunction

endpackage

// File: rtl/bp_track_fifo.sv
// In-order tracker of in-flight predicted branches: push at tail, pop at head, bulk clear.
module bp_track_fifo #(
   parameter int unsigned depth  = 4,
   parameter int unsigned data_w = 9,
   localparam int unsigned ptr_w = $clog2(depth),
   localparam int unsigned cnt_w = $clog2(depth) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [data_w-1:0] push_data_i,
   input  logic              pop_i,
   input  logic              clear_i,
   output logic [data_w-1:0] head_data_o,
   output logic [cnt_w-1:0]  count_o
);

   logic [data_w-1:0] mem_q [depth];
   logic [ptr_w-1:0]  head_q, head_d;
   logic [ptr_w-1:0]  tail_q, tail_d;
   logic [cnt_w-1:0]  count_q, count_d;
   logic              pop_ok, push_ok;

   assign pop_ok      = pop_i && (count_q != '0);
   // A full tracker still takes a push when the head leaves in the same cycle.
   assign push_ok     = push_i && ((count_q != cnt_w'(depth)) || pop_ok);
   assign head_data_o = mem_q[head_q];
   assign count_o     = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (pop_ok)  head_d = head_q + ptr_w'(1);
         if (push_ok) tail_d = tail_q + ptr_w'(1);
         count_d = count_q + cnt_w'(push_ok) - cnt_w'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !clear_i && push_ok) mem_q[tail_q] <= push_data_i;
   end

endmodule

// File: rtl/branch_update_ctrl.sv
// Tracks predicted branches until EX resolves them, then trains the predictor and
// reports mispredictions.
module branch_update_ctrl
   import branch_update_ctrl_pkg::*;
#(
   parameter int unsigned entry_num   = BP_ENTRY_NUM,
   parameter int unsigned addr_width  = $clog2(entry_num),
   parameter int unsigned track_depth = BP_TRACK_DEPTH
) (
   input  logic                          cpu_clk,
   input  logic                          cpu_rst,
   input  logic                          pred_push,
   input  logic [addr_width-1:0]         pred_push_addr,
   input  logic                          pred_push_taken,
   output logic                          pred_full,
   input  logic                          resolve_valid,
   input  logic                          branch_taken_ex,
   input  logic                          flush,
   output logic                          predictor_wen,
   output logic [addr_width-1:0]         predictor_waddr,
   output logic                          upd_taken,
   output logic                          mispredict,
   output logic [$clog2(track_depth):0]  track_count,
   output logic [PERF_CNT_W-1:0]         mispredict_cnt
);

   localparam int unsigned CntW = $clog2(track_depth) + 1;

   logic [addr_width:0]   head_data;
   logic [addr_width-1:0] head_addr;
   logic                  head_taken;
   logic                  resolve_ok, mis_now, fifo_clear, fifo_push;

   logic                  wen_q, wen_d;
   logic [addr_width-1:0] waddr_q, waddr_d;
   logic                  upd_taken_q, upd_taken_d;
   logic                  mispredict_q, mispredict_d;
   logic [PERF_CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

   assign head_addr  = head_data[addr_width:1];
   assign head_taken = head_data[0];
   assign pred_full  = (track_count == CntW'(track_depth));
   assign resolve_ok = resolve_valid && (track_count != '0);
   assign mis_now    = resolve_ok && (head_taken != branch_taken_ex);
   // A wrong head invalidates every younger entry, including one arriving now.
   assign fifo_clear = flush || mis_now;
   assign fifo_push  = pred_push && !fifo_clear && (!pred_full || resolve_ok);

   bp_track_fifo #(
      .depth  (track_depth),
      .data_w (addr_width + 1)
   ) u_track_fifo (
      .clk_i       (cpu_clk),
      .rst_i       (cpu_rst),
      .push_i      (fifo_push),
      .push_data_i ({pred_push_addr, pred_push_taken}),
      .pop_i       (resolve_ok),
      .clear_i     (fifo_clear),
      .head_data_o (head_data),
      .count_o     (track_count)
   );

   always_comb begin
      wen_d            = resolve_ok;
      waddr_d          = waddr_q;
      upd_taken_d      = upd_taken_q;
      mispredict_d     = mis_now;
      mispredict_cnt_d = mispredict_cnt_q;
      if (resolve_ok) begin
         waddr_d     = head_addr;
         upd_taken_d = branch_taken_ex;
      end
      if (mis_now) mispredict_cnt_d = sat_inc(mispredict_cnt_q);
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         wen_q            <= 1'b0;
         waddr_q          <= '0;
         upd_taken_q      <= 1'b0;
         mispredict_q     <= 1'b0;
         mispredict_cnt_q <= '0;
      end else begin
         wen_q            <= wen_d;
         waddr_q          <= waddr_d;
         upd_taken_q      <= upd_taken_d;
         mispredict_q     <= mispredict_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign predictor_wen   = wen_q;
   assign predictor_waddr = waddr_q;
   assign upd_taken       = upd_taken_q;
   assign mispredict      = mispredict_q;
   assign mispredict_cnt  = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Scoreboard bench: a queue-based reference tracker predicts updates and state per cycle.
module tb_branch_update_ctrl;
   import branch_update_ctrl_pkg::*;

   localparam int unsigned AW = 8;
   localparam int unsigned D  = 4;

   logic          cpu_clk, cpu_rst;
   logic          pred_push, pred_push_taken, pred_full;
   logic [AW-1:0] pred_push_addr;
   logic          resolve_valid, branch_taken_ex, flush;
   logic          predictor_wen, upd_taken, mispredict;
   logic [AW-1:0] predictor_waddr;
   logic [2:0]    track_count;
   logic [15:0]   mispredict_cnt;

   branch_update_ctrl #(
      .entry_num   (256),
      .addr_width  (AW),
      .track_depth (D)
   ) dut (
      .cpu_clk         (cpu_clk),
      .cpu_rst         (cpu_rst),
      .pred_push       (pred_push),
      .pred_push_addr  (pred_push_addr),
      .pred_push_taken (pred_push_taken),
      .pred_full       (pred_full),
      .resolve_valid   (resolve_valid),
      .branch_taken_ex (branch_taken_ex),
      .flush           (flush),
      .predictor_wen   (predictor_wen),
      .predictor_waddr (predictor_waddr),
      .upd_taken       (upd_taken),
      .mispredict      (mispredict),
      .track_count     (track_count),
      .mispredict_cnt  (mispredict_cnt)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   int cyc = 0;
   always @(posedge cpu_clk) cyc <= cyc + 1;

   typedef struct {int due; logic [AW-1:0] addr; logic taken; logic mis;} upd_t;
   typedef struct {int due; int count; logic [15:0] cnt; logic rst;} st_t;
   typedef struct {logic [AW-1:0] addr; logic taken;} ent_t;

   upd_t        upd_q[$];
   st_t         st_q[$];
   ent_t        m_q[$];
   logic [15:0] m_cnt = '0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle of stimulus plus the reference-model update for that cycle.
   task automatic step(input logic rst, input logic push, input logic [AW-1:0] a,
                       input logic pt, input logic rv, input logic bt, input logic fl,
                       input logic frc);
      logic hv, full, mis;
      @(negedge cpu_clk);
      if (frc) begin
         force dut.mispredict_cnt_q = 16'hFFFE;
         m_cnt = 16'hFFFE;
      end
      cpu_rst         = rst;
      pred_push       = push;
      pred_push_addr  = a;
      pred_push_taken = pt;
      resolve_valid   = rv;
      branch_taken_ex = bt;
      flush           = fl;
      if (rst) begin
         m_q.delete();
         m_cnt = '0;
      end else begin
         hv   = rv && (m_q.size() > 0);
         full = (m_q.size() == D);
         mis  = 1'b0;
         if (hv) begin
            mis = (m_q[0].taken != bt);
            upd_q.push_back('{due: cyc + 1, addr: m_q[0].addr, taken: bt, mis: mis});
            void'(m_q.pop_front());
         end
         if (mis && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (fl || mis) m_q.delete();
         else if (push && (!full || hv)) m_q.push_back('{addr: a, taken: pt});
      end
      st_q.push_back('{due: cyc + 1, count: m_q.size(), cnt: m_cnt, rst: rst});
      if (frc) begin
         #1;
         release dut.mispredict_cnt_q;
      end
   endtask

   task automatic idle();
      step(0, 0, '0, 0, 0, 0, 0, 0);
   endtask

   task automatic push_br(input logic [AW-1:0] a, input logic pt);
      step(0, 1, a, pt, 0, 0, 0, 0);
   endtask

   task automatic resolve(input logic bt);
      step(0, 0, '0, 0, 1, bt, 0, 0);
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   initial begin
      upd_t u;
      st_t  s;
      forever begin
         @(posedge cpu_clk);
         #2;
         if (upd_q.size() > 0 && upd_q[0].due == cyc) begin
            u = upd_q.pop_front();
            chk("wen", predictor_wen, 1);
            chk("waddr", predictor_waddr, u.addr);
            chk("upd_taken", upd_taken, u.taken);
            chk("mispredict", mispredict, u.mis);
         end else begin
            chk("wen_idle", predictor_wen, 0);
            chk("mispredict_idle", mispredict, 0);
         end
         if (st_q.size() > 0 && st_q[0].due == cyc) begin
            s = st_q.pop_front();
            chk("track_count", track_count, s.count);
            chk("pred_full", pred_full, (s.count == D));
            chk("mispredict_cnt", mispredict_cnt, s.cnt);
            if (s.rst) begin
               chk("rst_waddr", predictor_waddr, 0);
               chk("rst_upd_taken", upd_taken, 0);
            end
         end
      end
   end

   initial begin
      logic          rst, fl, push, rv, bt, pt;
      logic [AW-1:0] a;
      cpu_rst = 1'b1; pred_push = 0; pred_push_addr = '0; pred_push_taken = 0;
      resolve_valid = 0; branch_taken_ex = 0; flush = 0;
      step(1, 0, '0, 0, 0, 0, 0, 0);
      step(1, 1, 8'h33, 1, 1, 1, 1, 0);
      idle();

      // Correct prediction round trip.
      push_br(8'h10, 1); resolve(1); idle();

      // Mispredict at head discards younger entries.
      push_br(8'h05, 0); push_br(8'h06, 1); push_br(8'h07, 0); resolve(1); idle();

      // Full tracker, dropped push, push with same-cycle pop.
      push_br(8'h21, 1); push_br(8'h22, 0); push_br(8'h23, 1); push_br(8'h24, 1);
      push_br(8'h25, 1);
      step(0, 1, 8'h26, 0, 1, 1, 0, 0);
      resolve(0); resolve(1); resolve(1); resolve(0); idle();

      // Resolve on empty tracker.
      resolve(1); resolve(0); idle();

      // Flush with same-cycle correct resolve and push.
      push_br(8'h41, 1); push_br(8'h42, 0); push_br(8'h43, 1);
      step(0, 1, 8'h44, 1, 1, 1, 1, 0);
      idle(); resolve(1); idle();

      // Counter saturation, then reset mid-stream.
      step(0, 0, '0, 0, 0, 0, 0, 1);
      push_br(8'h51, 0); resolve(1);
      push_br(8'h52, 0); resolve(1);
      push_br(8'h53, 1); resolve(0);
      push_br(8'h54, 1); push_br(8'h55, 0); resolve(1);
      step(1, 1, 8'h56, 1, 1, 0, 0, 0);
      idle(); idle();

      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom % 100) == 0;
         fl   = ($urandom % 30) == 0;
         push = ($urandom % 10) < 6;
         rv   = ($urandom % 10) < 4;
         a    = AW'($urandom);
         pt   = 1'($urandom);
         if (m_q.size() > 0 && ($urandom % 4) != 0) bt = m_q[0].taken;
         else bt = 1'($urandom);
         step(rst, push, a, pt, rv, bt, fl, 0);
      end

      idle(); idle(); idle();
      @(negedge cpu_clk);
      chk("scoreboard_drained", upd_q.size() + st_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
